// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the handshaked pipeline stage registers.
//   pipe_state_t : fill state of a two-entry skid stage (EMPTY, ONE, FULL)
//   OCC_W        : width of the occupancy output (counts 0..2)
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// sat_counter: saturating up-counter used for performance statistics.
//   clk   : clock, counts on rising edge
//   reset : asynchronous active-high clear
//   inc   : add one this cycle (ignored once the counter is at all-ones)
//   count : current value, held at 2^CNT_W-1 once reached
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    // NOTE: the default assignment first means every path assigns count_d,
    // so no latch is inferred.
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments for flops so every register samples
    // pre-edge values regardless of block evaluation order.
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage register with a two-entry
// skid buffer. in_ready and out_valid come straight from flops, so there
// is no combinational path from out_ready back to in_ready.
//   clk, reset          : clock and asynchronous active-high reset
//   flush               : synchronous kill of held and incoming beats
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and payload
//   occupancy           : entries currently held (0..2)
//   stall_cnt           : saturating count of out_valid & ~out_ready cycles
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t       state_q, state_d;
  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = main_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;

    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_data_d = in_data;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_data_d = in_data;
        end else if (in_fire) begin
          // Downstream stalled: park the beat that was already promised
          // a slot by the registered in_ready.
          skid_data_d = in_data;
          state_d     = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_data_d = skid_data_q;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush wins over everything; an out_fire this cycle has still been
    // handed downstream, an in_fire is simply dropped.
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = RESET_VAL;
      skid_data_d = RESET_VAL;
    end

    // Handshake flags are decoded from the next state so they can be
    // registered and still be correct in the cycle they are used.
    main_valid_d = (state_d != EMPTY);
    skid_valid_d = (state_d == FULL);
    in_ready_d   = (state_d != FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the data registers are reset on purpose: out_data must read
    // RESET_VAL while idle after reset, so this is not a plain memory.
    if (reset) begin
      state_q      <= EMPTY;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      main_data_q  <= RESET_VAL;
      skid_data_q  <= RESET_VAL;
    end else begin
      state_q      <= state_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign occupancy = OCC_W'(main_valid_q) + OCC_W'(skid_valid_q);

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (main_valid_q & ~out_ready),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed tests on a 32-bit stage (CNT_W=4) with a
// scoreboard queue, plus a random valid/ready run on 1-bit and 128-bit
// stages checked against a reference queue and occupancy model.
module tb_pipe_stage_skid;

  localparam logic [31:0]  RST_V   = 32'hDEAD_BEEF;
  localparam logic [127:0] RST_V_W = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed DUT ----------------
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0]  occupancy;
  logic [3:0]  stall_cnt;

  pipe_stage_skid #(.DATA_W(32), .RESET_VAL(RST_V), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [31:0] data;
    int          due;   // cycle the beat must be consumed in, 0 = any
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_delivered = 0;

  // Monitor: inputs change just after posedge, so at negedge the values
  // describe the transfer about to happen on the next edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_delivered++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got beat 0x%0h, required no beat", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", out_data, mon_e.data);
        if (mon_e.due != 0) check("out_latency", cyc, mon_e.due);
      end
    end
    if (flush) exp_q.delete();
  end

  task automatic send(input logic [31:0] d, input bit timed);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 1'b0, 1'b1);
    end else begin
      exp_q.push_back('{data: d, due: (timed ? cyc + 1 : 0)});
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    step();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- random DUTs ----------------
  logic         r_reset, r_flush, r_in_valid, r_out_ready;
  logic [127:0] r_data;
  logic         n_in_ready, n_out_valid, n_out_data;
  logic         w_in_ready, w_out_valid;
  logic [127:0] w_out_data;
  logic [1:0]   n_occ, w_occ;
  logic [15:0]  n_stall, w_stall;
  bit           r_active = 1'b0;
  bit           r_done   = 1'b0;

  pipe_stage_skid #(.DATA_W(1), .RESET_VAL(1'b1), .CNT_W(16)) u_narrow (
    .clk(clk), .reset(r_reset), .flush(r_flush),
    .in_valid(r_in_valid), .in_ready(n_in_ready), .in_data(r_data[0]),
    .out_valid(n_out_valid), .out_ready(r_out_ready), .out_data(n_out_data),
    .occupancy(n_occ), .stall_cnt(n_stall)
  );

  pipe_stage_skid #(.DATA_W(128), .RESET_VAL(RST_V_W), .CNT_W(16)) u_wide (
    .clk(clk), .reset(r_reset), .flush(r_flush),
    .in_valid(r_in_valid), .in_ready(w_in_ready), .in_data(r_data),
    .out_valid(w_out_valid), .out_ready(r_out_ready), .out_data(w_out_data),
    .occupancy(w_occ), .stall_cnt(w_stall)
  );

  logic [127:0] r_q[$];
  logic [127:0] r_e;
  int           occ_m = 0;
  bit           r_ifire, r_ofire;

  // Model occupancy = accepted - delivered - flushed.
  always @(negedge clk) begin
    if (r_active) begin
      check("rand_occ_wide", w_occ, occ_m);
      check("rand_occ_narrow", n_occ, occ_m);
      r_ifire = r_in_valid && w_in_ready;
      r_ofire = w_out_valid && r_out_ready;
      if (r_ofire) begin
        if (r_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rand_unexpected_out: got beat 0x%0h, required no beat", w_out_data);
        end else begin
          r_e = r_q.pop_front();
          check("rand_data_wide", w_out_data, r_e);
          check("rand_data_narrow", n_out_data, r_e[0]);
        end
      end
      if (r_flush) begin
        r_q.delete();
        occ_m = 0;
      end else begin
        if (r_ifire) r_q.push_back(r_data);
        occ_m = occ_m + int'(r_ifire) - int'(r_ofire);
      end
    end
  end

  initial begin
    bit fired;
    r_reset     = 1'b1;
    r_flush     = 1'b0;
    r_in_valid  = 1'b0;
    r_out_ready = 1'b0;
    r_data      = '0;
    step();
    step();
    r_reset  = 1'b0;
    r_active = 1'b1;
    for (int i = 0; i < 600; i++) begin
      fired = r_in_valid && w_in_ready;
      step();
      if (!r_in_valid || fired) begin
        r_in_valid = ($urandom_range(0, 99) < 60);
        r_data     = {$urandom, $urandom, $urandom, $urandom};
      end
      r_out_ready = ($urandom_range(0, 99) < 50);
      r_flush     = ($urandom_range(0, 99) < 4);
    end
    r_in_valid  = 1'b0;
    r_flush     = 1'b0;
    r_out_ready = 1'b1;
    repeat (4) step();
    check("rand_drain", r_q.size(), 0);
    r_done = 1'b1;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int d0;
    int n;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_occupancy", occupancy, 2'd0);
    check("rst_stall_cnt", stall_cnt, 4'd0);
    check("rst_out_data", out_data, RST_V);

    // Streaming: one beat per cycle, each consumed one cycle after entry.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("stream_in_ready", in_ready, 1'b1);
      send(32'(i), 1'b1);
    end
    drain();

    // Backpressure: A and B fill the stage, C waits upstream.
    out_ready = 1'b0;
    send(32'hA, 1'b0);
    send(32'hB, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'hC;
    step();
    step();
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_occupancy", occupancy, 2'd2);
    check("bp_out_valid", out_valid, 1'b1);
    check("bp_out_data", out_data, 32'hA);
    out_ready = 1'b1;
    send(32'hC, 1'b0);
    drain();

    // Flush while FULL: held A leaves in the flush cycle, B is killed.
    out_ready = 1'b0;
    send(32'hA, 1'b0);
    send(32'hB, 1'b0);
    d0        = n_delivered;
    in_valid  = 1'b1;
    in_data   = 32'h77;
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_full_delivered", n_delivered - d0, 1);
    check("flush_full_out_valid", out_valid, 1'b0);
    check("flush_full_occupancy", occupancy, 2'd0);
    check("flush_full_out_data", out_data, RST_V);
    check("flush_full_in_ready", in_ready, 1'b1);
    repeat (3) step();

    // Flush in ONE with an accepted incoming beat: both are dropped.
    out_ready = 1'b0;
    send(32'h11, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h22;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_one_occupancy", occupancy, 2'd0);
    check("flush_one_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (3) step();

    // Stall counter saturation at 15.
    do_reset();
    check("sat_start", stall_cnt, 4'd0);
    out_ready = 1'b0;
    send(32'h5, 1'b0);
    repeat (14) step();
    check("sat_count14", stall_cnt, 4'd14);
    repeat (6) step();
    check("sat_count_max", stall_cnt, 4'd15);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("sat_after_flush", stall_cnt, 4'd15);
    do_reset();
    check("sat_after_reset", stall_cnt, 4'd0);

    // Asynchronous reset mid-cycle while FULL.
    out_ready = 1'b0;
    send(32'h1, 1'b0);
    send(32'h2, 1'b0);
    check("areset_pre_occ", occupancy, 2'd2);
    #3;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("areset_out_valid", out_valid, 1'b0);
    check("areset_in_ready", in_ready, 1'b1);
    check("areset_occupancy", occupancy, 2'd0);
    check("areset_out_data", out_data, RST_V);
    check("areset_stall_cnt", stall_cnt, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    out_ready = 1'b1;
    send(32'h55, 1'b1);
    drain();

    n = 0;
    while (!r_done && n < 5000) begin
      step();
      n++;
    end
    check("rand_finished", r_done, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
